// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state enum, default sizes and stage-control bundle for pipe_stall_ctrl.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, WAIT, HALT} state_t;
  localparam int MAX_WAIT_DEF = 15;
  localparam int CNT_W_DEF = 32;
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_write;
    logic mem_wb_bubble;
  } stage_ctrl_t;
  localparam stage_ctrl_t CTL_OFF = 7'b0000000;
  localparam stage_ctrl_t CTL_RUN = 7'b1101010;
  localparam stage_ctrl_t CTL_LU  = 7'b0001110;
  localparam stage_ctrl_t CTL_BR  = 7'b1111010;
  localparam stage_ctrl_t CTL_FRZ = 7'b0000001;
endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if: hazard/memory inputs, per-stage controls and perf counters of the stall sequencer.
interface pipe_stall_ctrl_if #(parameter int CNT_W = 32);
  logic load_use_hz;
  logic branch_taken_id;
  logic jump_id;
  logic dmem_req;
  logic dmem_ready;
  logic perf_clr;
  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_write;
  logic id_ex_bubble;
  logic ex_mem_write;
  logic mem_wb_bubble;
  logic halted;
  logic mem_err;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] wait_cnt;
  modport master (
    output load_use_hz, branch_taken_id, jump_id, dmem_req, dmem_ready, perf_clr,
    input pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write,
    input mem_wb_bubble, halted, mem_err, cyc_cnt, stall_cnt, flush_cnt, wait_cnt
  );
  modport slave (
    input load_use_hz, branch_taken_id, jump_id, dmem_req, dmem_ready, perf_clr,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write,
    output mem_wb_bubble, halted, mem_err, cyc_cnt, stall_cnt, flush_cnt, wait_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: counter that sticks at all-ones; clr wins over inc.
module sat_counter #(parameter int W = 32) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (clr) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall/flush sequencer with memory-wait timeout; perf counters built when PIPE_PERF_CNT_EN is defined.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic rst,
  pipe_stall_ctrl_if.slave bus
);
  state_t state, nxt;
  logic [7:0] wcnt, wcnt_nxt;
  stage_ctrl_t ctl, ctl_o;
  logic err, mem_wait, redirect;
  assign mem_wait = bus.dmem_req & ~bus.dmem_ready;
  assign redirect = bus.branch_taken_id | bus.jump_id;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      wcnt <= '0;
    end else begin
      state <= nxt;
      wcnt <= wcnt_nxt;
    end
  always_comb begin
    nxt = state;
    wcnt_nxt = wcnt;
    err = 1'b0;
    ctl = state == HALT ? CTL_OFF : mem_wait ? CTL_FRZ : bus.load_use_hz ? CTL_LU : redirect ? CTL_BR : CTL_RUN;
    if (state != HALT && mem_wait) begin
      if (state == RUN) begin
        nxt = WAIT;
        wcnt_nxt = 8'd1;
      end else if (wcnt == 8'(MAX_WAIT)) begin
        nxt = HALT;
        err = 1'b1;
      end else wcnt_nxt = wcnt + 8'd1;
    end else if (state == WAIT) begin
      nxt = RUN;
      wcnt_nxt = '0;
    end
  end
  // reset forces every control low, independent of the decode
  assign ctl_o = rst ? CTL_OFF : ctl;
  assign bus.pc_write = ctl_o.pc_write;
  assign bus.if_id_write = ctl_o.if_id_write;
  assign bus.if_id_flush = ctl_o.if_id_flush;
  assign bus.id_ex_write = ctl_o.id_ex_write;
  assign bus.id_ex_bubble = ctl_o.id_ex_bubble;
  assign bus.ex_mem_write = ctl_o.ex_mem_write;
  assign bus.mem_wb_bubble = ctl_o.mem_wb_bubble;
  assign bus.halted = ~rst & (state == HALT);
  assign bus.mem_err = ~rst & err;
`ifdef PIPE_PERF_CNT_EN
  sat_counter #(.W(CNT_W)) u_cyc (
    .clk(clk), .rst(rst), .inc(1'b1), .clr(bus.perf_clr), .q(bus.cyc_cnt)
  );
  sat_counter #(.W(CNT_W)) u_stall (
    .clk(clk), .rst(rst), .inc(~ctl_o.pc_write & ~bus.halted), .clr(bus.perf_clr), .q(bus.stall_cnt)
  );
  sat_counter #(.W(CNT_W)) u_flush (
    .clk(clk), .rst(rst), .inc(ctl_o.if_id_flush), .clr(bus.perf_clr), .q(bus.flush_cnt)
  );
  sat_counter #(.W(CNT_W)) u_wait (
    .clk(clk), .rst(rst), .inc(mem_wait & (state != HALT)), .clr(bus.perf_clr), .q(bus.wait_cnt)
  );
`else
  assign bus.cyc_cnt = '0;
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
  assign bus.wait_cnt = '0;
`endif
endmodule
